// File: rtl/thirty_two_three_demux_reg.sv
// rtl/thirty_two_three_demux_reg.sv - registered 1-to-8 valid/ready word distributor
// Optional DEMUX_STATS_EN builds saturating accept/stall counters; otherwise they read zero.
module thirty_two_three_demux_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [15:0]        xfer_count,
  output logic [15:0]        stall_count
);

  logic [7:0]       full_q, full_d;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic             accept;

  // A full channel still accepts when its consumer drains in the same cycle.
  assign in_ready = !flush && (!full_q[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    full_d = full_q & ~out_ready;
    data_d = data_q;
    if (accept) begin
      full_d[in_sel] = 1'b1;
      data_d[in_sel] = in_data;
    end
    if (flush) begin
      full_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;

  for (genvar g = 0; g < 8; g++) begin : g_out
    assign out_data[WIDTH*g +: WIDTH] = data_q[g];
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] xfer_q, xfer_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    if (accept && (xfer_q != 16'hFFFF)) begin
      xfer_d = xfer_q + 16'd1;
    end
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Counters survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q  <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end

  assign xfer_count  = xfer_q;
  assign stall_count = stall_q;
`else
  assign xfer_count  = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_thirty_two_three_demux_reg.sv
// tb/tb_thirty_two_three_demux_reg.sv - table-driven bench for thirty_two_three_demux_reg
module tb_thirty_two_three_demux_reg;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_sel;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [15:0]        xfer_count;
  logic [15:0]        stall_count;

  thirty_two_three_demux_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [2:0]  sel;
    logic [31:0] dat;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_ov;
    logic [2:0]  ch;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [29];
  int   checks = 0;
  int   errors = 0;
  int   mx = 0;
  int   ms = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic fl, input logic iv, input logic [2:0] sel,
                         input logic [31:0] dat, input logic [7:0] ordy, input logic rdy,
                         input logic [7:0] ov, input logic [2:0] ch, input logic [31:0] ed);
    vecs[i] = '{fl, iv, sel, dat, ordy, rdy, ov, ch, ed};
  endtask

  task automatic apply(input int i);
    flush     = vecs[i].fl;
    in_valid  = vecs[i].iv;
    in_sel    = vecs[i].sel;
    in_data   = vecs[i].dat;
    out_ready = vecs[i].ordy;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
    if (vecs[i].iv && vecs[i].exp_rdy) mx++;
    else if (vecs[i].iv) ms++;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", i), {24'd0, out_valid}, {24'd0, vecs[i].exp_ov});
    chk($sformatf("v%0d data ch%0d", i, vecs[i].ch), out_data[vecs[i].ch*WIDTH +: WIDTH],
        vecs[i].exp_dat);
  endtask

  task automatic drive(input logic iv, input logic [2:0] sel, input logic [31:0] dat,
                       input logic [7:0] ordy);
    flush = 1'b0; in_valid = iv; in_sel = sel; in_data = dat; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag, input int ex, input int es);
`ifdef DEMUX_STATS_EN
    chk({tag, " xfer_count"}, {16'd0, xfer_count}, ex);
    chk({tag, " stall_count"}, {16'd0, stall_count}, es);
`else
    chk({tag, " xfer_count"}, {16'd0, xfer_count}, 32'd0);
    chk({tag, " stall_count"}, {16'd0, stall_count}, 32'd0);
    if (ex < 0 || es < 0) $display("unexpected negative count");
`endif
  endtask

  initial begin
    // single write and stall
    set_vec(0, 0, 1, 5, 32'hDEADBEEF, 8'h00, 1, 8'h20, 5, 32'hDEADBEEF);
    set_vec(1, 0, 1, 5, 32'h12345678, 8'h00, 0, 8'h20, 5, 32'hDEADBEEF);
    set_vec(2, 0, 0, 0, 32'h0,        8'h20, 1, 8'h00, 5, 32'hDEADBEEF);
    // back-to-back on channel 2 with consumer always ready
    set_vec(3, 0, 1, 2, 32'd1, 8'h04, 1, 8'h04, 2, 32'd1);
    set_vec(4, 0, 1, 2, 32'd2, 8'h04, 1, 8'h04, 2, 32'd2);
    set_vec(5, 0, 1, 2, 32'd3, 8'h04, 1, 8'h04, 2, 32'd3);
    set_vec(6, 0, 0, 0, 32'd0, 8'h04, 1, 8'h00, 2, 32'd3);
    // fill all channels, then check every slice and blocked in_ready
    for (int k = 0; k < 8; k++) begin
      set_vec(7 + k, 0, 1, k[2:0], k * 32'h11111111, 8'h00, 1,
              8'((1 << (k + 1)) - 1), k[2:0], k * 32'h11111111);
      set_vec(15 + k, 0, 0, k[2:0], 32'h0, 8'h00, 0, 8'hFF, k[2:0], k * 32'h11111111);
    end
    set_vec(23, 0, 0, 0, 32'h0, 8'hFF, 1, 8'h00, 0, 32'h0);
    // flush beats a pending accept on channel 4
    set_vec(24, 0, 1, 1, 32'h0000AAAA, 8'h00, 1, 8'h02, 1, 32'h0000AAAA);
    set_vec(25, 0, 1, 6, 32'h00006666, 8'h00, 1, 8'h42, 6, 32'h00006666);
    set_vec(26, 1, 1, 4, 32'h00004444, 8'h00, 0, 8'h00, 4, 32'h44444444);
    set_vec(27, 0, 0, 1, 32'h0,        8'h00, 1, 8'h00, 1, 32'h0000AAAA);
    set_vec(28, 0, 1, 6, 32'h00007777, 8'h00, 1, 8'h40, 6, 32'h00007777);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 3'd0;
    in_data = '0; out_ready = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", {24'd0, out_valid}, 32'd0);
    chk("reset out_data", {31'd0, |out_data}, 32'd0);
    for (int s = 0; s < 8; s++) begin
      in_sel = s[2:0];
      #1;
      chk($sformatf("reset in_ready sel%0d", s), {31'd0, in_ready}, 32'd1);
    end
    chk_counters("reset", 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) apply(i);
    chk_counters("table", mx, ms);

    // 5 accepts + 3 stalls from a fresh reset
    in_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 32'hA0, 8'h00);
    repeat (3) drive(1, 0, 32'hA1, 8'h00);
    chk("stats ch0 held", out_data[0 +: WIDTH], 32'hA0);
    for (int j = 0; j < 4; j++) drive(1, 0, 32'hB0 + j, 8'h01);
    chk("stats ch0 last", out_data[0 +: WIDTH], 32'hB3);
    chk_counters("stats", 5, 3);

    // asynchronous reset mid-burst clears everything immediately
    drive(1, 3, 32'hC3, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", {24'd0, out_valid}, 32'd0);
    chk("async out_data", {31'd0, |out_data}, 32'd0);
    chk_counters("async", 0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thirty_two_three_demux_reg.md
Name: thirty_two_three_demux_reg

Overview:
- Registered 1-to-8 distributor; the opposite direction of the ALU 8:1 result mux.
- Takes one WIDTH-bit word plus a 3-bit destination select on a valid/ready input port.
- Parks the word in one of eight per-channel holding registers, each drained by its own valid/ready output channel.
- Sits between the ALU result path and eight downstream consumers (register write ports, flag logic, shifter feedback).

Parameters:
- WIDTH, 32, data width of the input word and of each output channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all channel holding flags.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid is also 1.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  3  destination channel 0..7.
- out_valid  output  8  bit k: channel k holds a word.
- out_ready  input  8  bit k: consumer k takes the word this cycle.
- out_data  output  8*WIDTH  channel k at [WIDTH*k+WIDTH-1 : WIDTH*k].
- xfer_count  output  16  accepted-input counter (see Optional Feature).
- stall_count  output  16  input-stall counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): all full[7:0]=0, all holding registers=0, out_valid=0, out_data=0, counters=0. Reset mid-operation discards held words; no output transfer completes in that cycle.
- out_valid[k] = full[k], registered. out_data slice k = holding register k, registered, stable while out_valid[k]=1 and not drained.
- in_ready = !flush && (!full[in_sel] || out_ready[in_sel]). Combinational from flush, in_sel, full and out_ready; no other comb path.
- Accept (in_valid && in_ready): reg[in_sel] <= in_data; full[in_sel] <= 1. Latency is 1 cycle: word is visible on channel in_sel the next cycle.
- Drain (out_valid[k] && out_ready[k]): full[k] <= 0 unless channel k is refilled in the same cycle.
- Simultaneous drain and accept on the same channel: full stays 1, register takes the new word. Gives full throughput of one word per cycle per channel.
- Drains on other channels are independent; up to 8 drains plus 1 accept per cycle.
- Channel full and its out_ready=0: in_ready=0; in_data/in_sel may change freely (no ordering guarantee required from upstream).
- out_ready[k] while out_valid[k]=0: ignored.
- flush=1: full[7:0] <= 0 next edge. Holding registers keep their values but are invalid. in_ready=0, so no accept. flush wins over any simultaneous drain/accept.
- in_sel is always a legal channel (3 bits, 8 channels); no error state.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - xfer_count increments on every accepted input word.
  - stall_count increments every cycle with in_valid=1 && in_ready=0 (including flush cycles).
  - Both are 16-bit, saturate at 16'hFFFF, cleared by rst_n only (not by flush).
- Undefined: xfer_count and stall_count are tied to 16'h0000 and no counter flops are built. Ports remain present.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> out_valid=8'h00, out_data all zero, in_ready=1 for every in_sel.
- Single write: in_data=32'hDEADBEEF, in_sel=3'd5, in_valid=1 one cycle, out_ready=0 -> next cycle out_valid=8'b0010_0000, slice 5=32'hDEADBEEF; second word to sel 5 sees in_ready=0.
- Back-to-back same channel: out_ready[2]=1 held, words 1,2,3 to sel 2 on consecutive cycles -> in_ready=1 every cycle; channel 2 shows 1,2,3 on consecutive cycles, out_valid[2] drops the cycle after the last.
- All channels: write k*32'h11111111 to sel k for k=0..7, out_ready=0 -> out_valid=8'hFF, each slice correct; then out_ready=8'hFF for 1 cycle -> out_valid=8'h00.
- Flush: channels 1 and 6 full, flush=1 with in_valid=1 to sel 4 -> in_ready=0, next cycle out_valid=8'h00, channel 4 not written.
- Stats (DEMUX_STATS_EN): 5 accepts plus 3 stalled cycles -> xfer_count=5, stall_count=3. Async reset mid-burst -> both 0 immediately. Without the macro both read 0 throughout.
